// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Pays out an amount of change (units of 10 sen) one coin at a time. It always
// picks the largest denomination that still fits and whose tube is not empty.
// A coin is offered on coin_valid/coin_sel and held until the mechanism acks
// it. A missing ack times out after COIN_TO cycles and reports a fault.
//
// Parameters
//   COIN_TO    : ISSUE cycles without coin_ack before the payout faults (<=255)
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : one-cycle payout request, honoured only when idle
//   amount     : change owed, units of 10 sen
//   abort      : stop the payout early (SELECT / ISSUE)
//   empty      : tube empty flags [3]=RM1 [2]=50sen [1]=20sen [0]=10sen
//   coin_ack   : mechanism has ejected the offered coin
//   coin_valid : coin ejection request
//   coin_sel   : offered denomination 3=RM1 2=50sen 1=20sen 0=10sen
//   busy       : payout in progress
//   done       : one-cycle completion pulse
//   short      : amount not fully paid (valid with done)
//   fault      : ack timeout (valid with done)
//   remaining  : unpaid units, held after done until the next start
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int COIN_TO = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       abort,
  input  logic [3:0] empty,
  input  logic       coin_ack,
  output logic       coin_valid,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic       fault,
  output logic [7:0] remaining
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [8:0] COIN_TO_W = 9'(COIN_TO);

  // Value of a denomination code in units of 10 sen.
  function automatic logic [7:0] coin_value(input logic [1:0] sel);
    logic [7:0] v;
    case (sel)
      2'd3:    v = 8'd10;
      2'd2:    v = 8'd5;
      2'd1:    v = 8'd2;
      default: v = 8'd1;
    endcase
    return v;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic       short_q, short_d;
  logic       fault_q, fault_d;
  logic       coin_valid_q, coin_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] ack_rem_s;
  logic       timeout_s;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rem_q        <= 8'd0;
      cnt_q        <= 8'd0;
      sel_q        <= 2'd0;
      short_q      <= 1'b0;
      fault_q      <= 1'b0;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      short_q      <= short_d;
      fault_q      <= fault_d;
      coin_valid_q <= coin_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state, remainder, timeout counter, coin selection and done flags.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    short_d   = 1'b0;
    fault_d   = 1'b0;
    // Cannot underflow: a coin is only offered if its value fits the remainder.
    ack_rem_s = rem_q - coin_value(sel_q);
    timeout_s = (({1'b0, cnt_q} + 9'd1) >= COIN_TO_W);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SELECT;
          rem_d   = amount;
          cnt_d   = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      SELECT: begin
        cnt_d = 8'd0;
        if (abort || (rem_q == 8'd0)) begin
          state_d = DONE;
          short_d = (rem_q != 8'd0);
        end else if (!empty[3] && (rem_q >= 8'd10)) begin
          state_d = ISSUE;
          sel_d   = 2'd3;
        end else if (!empty[2] && (rem_q >= 8'd5)) begin
          state_d = ISSUE;
          sel_d   = 2'd2;
        end else if (!empty[1] && (rem_q >= 8'd2)) begin
          state_d = ISSUE;
          sel_d   = 2'd1;
        end else if (!empty[0]) begin
          state_d = ISSUE;
          sel_d   = 2'd0;
        end else begin
          state_d = DONE;
          short_d = 1'b1;
        end
      end
      ISSUE: begin
        if (coin_ack) begin
          // The ack is honoured first so an abort on the same edge sees the
          // reduced remainder.
          rem_d = ack_rem_s;
          cnt_d = 8'd0;
          if (abort) begin
            state_d = DONE;
            short_d = (ack_rem_s != 8'd0);
          end else begin
            state_d = SELECT;
          end
        end else if (timeout_s) begin
          state_d = DONE;
          cnt_d   = cnt_q + 8'd1;
          fault_d = 1'b1;
          short_d = 1'b1;
        end else if (abort) begin
          state_d = DONE;
          cnt_d   = cnt_q + 8'd1;
          short_d = (rem_q != 8'd0);
        end else begin
          state_d = ISSUE;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    coin_valid_d = (state_d == ISSUE);
    busy_d       = (state_d == SELECT) || (state_d == ISSUE);
    done_d       = (state_d == DONE);
  end

  assign coin_valid = coin_valid_q;
  assign coin_sel   = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign short      = short_q;
  assign fault      = fault_q;
  assign remaining  = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Directed and randomized payouts checked against a transaction-level model:
// the bench acts as the coin mechanism, predicts each coin from the greedy
// rule (largest fitting, non-empty denomination) and tracks the remainder.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

  localparam int COIN_TO = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] amount;
  logic       abort;
  logic [3:0] empty;
  logic       coin_ack;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       busy;
  logic       done;
  logic       short;
  logic       fault;
  logic [7:0] remaining;

  int checks;
  int failures;
  int coins_q[$];
  int denom_val[4] = '{1, 2, 5, 10};

  change_dispenser #(.COIN_TO(COIN_TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .amount     (amount),
    .abort      (abort),
    .empty      (empty),
    .coin_ack   (coin_ack),
    .coin_valid (coin_valid),
    .coin_sel   (coin_sel),
    .busy       (busy),
    .done       (done),
    .short      (short),
    .fault      (fault),
    .remaining  (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Greedy choice: code of largest denomination fitting rem with a full tube.
  function automatic int pick(input int rem, input logic [3:0] emp);
    for (int d = 3; d >= 0; d--) begin
      if (!emp[d] && denom_val[d] <= rem) return d;
    end
    return -1;
  endfunction

  task automatic check_done(input string tag, input int rem, input bit exp_short, input bit exp_fault);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, coin_valid, 0);
    check({tag, "_short"}, short, exp_short);
    check({tag, "_fault"}, fault, exp_fault);
    check({tag, "_rem"}, remaining, rem);
  endtask

  // One complete payout, called at a negedge while idle.
  // ack_lat   : ISSUE cycle index of coin_ack (-1 = never)
  // abort_coin: coin index at which abort is raised (with its ack if any)
  // poke_start: pulse a bogus start during the first ISSUE cycle
  task automatic do_payout(input int amt, input logic [3:0] emp, input int ack_lat,
                           input int abort_coin, input bit poke_start, output int rem_out);
    int  rem, coin, sel, k;
    bit  fin, acked, ack_now, ab_now;
    coins_q.delete();
    start  = 1'b1;
    amount = amt[7:0];
    empty  = emp;
    @(negedge clk);
    start  = 1'b0;
    amount = 8'h00;
    rem    = amt;
    coin   = 0;
    check("load_busy", busy, 1);
    check("load_rem", remaining, rem);
    check("load_valid", coin_valid, 0);
    check("load_done", done, 0);
    fin = 1'b0;
    while (!fin) begin
      empty = emp;
      sel   = pick(rem, emp);
      @(negedge clk);
      if (sel < 0) begin
        check_done("sel", rem, rem != 0, 1'b0);
        fin = 1'b1;
      end else begin
        k     = 0;
        acked = 1'b0;
        while (!fin && !acked) begin
          check("iss_valid", coin_valid, 1);
          check("iss_sel", coin_sel, sel);
          check("iss_busy", busy, 1);
          check("iss_rem", remaining, rem);
          check("iss_short", short, 0);
          // Tube flags seen during ISSUE must not matter.
          empty = 4'($urandom_range(0, 15));
          if (poke_start && coin == 0 && k == 0) begin
            start  = 1'b1;
            amount = 8'hFF;
          end
          ack_now  = (ack_lat >= 0) && (k == ack_lat);
          ab_now   = (coin == abort_coin) && ((ack_lat < 0) ? (k == 0) : (k == ack_lat));
          coin_ack = ack_now;
          abort    = ab_now;
          @(negedge clk);
          coin_ack = 1'b0;
          abort    = 1'b0;
          start    = 1'b0;
          amount   = 8'h00;
          if (ack_now) begin
            rem = rem - denom_val[sel];
            coins_q.push_back(sel);
            coin++;
            acked = 1'b1;
            if (ab_now) begin
              check_done("abort_ack", rem, rem != 0, 1'b0);
              fin = 1'b1;
            end
          end else if (k + 1 >= COIN_TO) begin
            check_done("timeout", rem, 1'b1, 1'b1);
            fin = 1'b1;
          end else if (ab_now) begin
            check_done("abort", rem, 1'b1, 1'b0);
            fin = 1'b1;
          end else begin
            k++;
          end
        end
      end
    end
    // DONE lasts one cycle, then idle with the remainder held.
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_short", short, 0);
    check("idle_fault", fault, 0);
    check("idle_valid", coin_valid, 0);
    check("idle_rem", remaining, rem);
    @(negedge clk);
    check("hold_rem", remaining, rem);
    rem_out = rem;
  endtask

  initial begin
    int r;
    int amt, lat, abc;
    logic [3:0] emp;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    start    = 1'b0;
    amount   = 8'h00;
    abort    = 1'b0;
    empty    = 4'h0;
    coin_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", coin_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rem", remaining, 0);
    check("rst_sel", coin_sel, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // 18 units, all tubes full, ack one cycle after valid.
    do_payout(18, 4'b0000, 1, -1, 1'b0, r);
    check("s1_rem", r, 0);
    check("s1_ncoins", coins_q.size(), 4);
    if (coins_q.size() == 4) begin
      check("s1_c0", coins_q[0], 3);
      check("s1_c1", coins_q[1], 2);
      check("s1_c2", coins_q[2], 1);
      check("s1_c3", coins_q[3], 0);
    end

    // 5 units with 50 sen tube empty -> 20, 20, 10.
    do_payout(5, 4'b0100, 0, -1, 1'b0, r);
    check("s2_ncoins", coins_q.size(), 3);
    if (coins_q.size() == 3) begin
      check("s2_c0", coins_q[0], 1);
      check("s2_c1", coins_q[1], 1);
      check("s2_c2", coins_q[2], 0);
    end

    // 3 units with 10 sen tube empty -> one 20 sen, short by 1.
    do_payout(3, 4'b0001, 1, -1, 1'b0, r);
    check("s3_rem", r, 1);
    check("s3_ncoins", coins_q.size(), 1);

    // No ack ever -> timeout after COIN_TO ISSUE cycles.
    do_payout(10, 4'b0000, -1, -1, 1'b0, r);
    check("s4_rem", r, 10);

    // 20 units, abort on the first ack -> short with 10 left.
    do_payout(20, 4'b0000, 0, 0, 1'b0, r);
    check("s5_rem", r, 10);

    // Reset mid-ISSUE clears everything at once.
    start  = 1'b1;
    amount = 8'd20;
    empty  = 4'b0000;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", coin_valid, 1);
    rst = 1'b0;
    #1;
    check("arst_valid", coin_valid, 0);
    check("arst_sel", coin_sel, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_short", short, 0);
    check("arst_fault", fault, 0);
    check("arst_rem", remaining, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("quiet_valid", coin_valid, 0);
      check("quiet_busy", busy, 0);
    end

    // Start during busy is ignored.
    do_payout(7, 4'b0000, 1, -1, 1'b1, r);
    check("s6_rem", r, 0);

    // Zero amount: done two cycles after start, no coins.
    do_payout(0, 4'b0000, 0, -1, 1'b0, r);
    check("s7_ncoins", coins_q.size(), 0);
    check("s7_rem", r, 0);

    // Randomized payouts.
    for (int n = 0; n < 25; n++) begin
      amt = $urandom_range(0, 255);
      emp = 4'($urandom_range(0, 15));
      lat = $urandom_range(0, 3);
      abc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      do_payout(amt, emp, lat, abc, 1'b0, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
